// File: rtl/risc_pipe_core_if.sv
// Load and writeback bus of risc_pipe_core: IMEM/RF preload ports in, retiring result out.
interface risc_pipe_core_if #(
   parameter int DATA_W     = 32,
   parameter int IMEM_WORDS = 16
);
   localparam int AW = $clog2(IMEM_WORDS);

   logic              imem_we;
   logic [AW-1:0]     imem_waddr;
   logic [31:0]       imem_wdata;
   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output imem_we, imem_waddr, imem_wdata, rf_we, rf_waddr, rf_wdata,
      input  wb_valid, wb_rd, wb_data
   );

   modport slave (
      input  imem_we, imem_waddr, imem_wdata, rf_we, rf_waddr, rf_wdata,
      output wb_valid, wb_rd, wb_data
   );
endinterface

// File: rtl/risc_pipe_core.sv
// Three-stage IF -> ID -> EX RISC core with EX/WB register, HALT drain, run/freeze,
// loadable IMEM/RF, and either EX->ID forwarding or a one-cycle stall interlock.
module risc_pipe_core #(
   parameter int DATA_W     = 32,
   parameter int IMEM_WORDS = 16,
   parameter int FORWARD    = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             run,
   risc_pipe_core_if.slave  bus,
   output logic             halted,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int          AW       = $clog2(IMEM_WORDS);
   localparam logic [31:0] NOP_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {ST_RUN = 2'b00, ST_DRAIN = 2'b01, ST_HALT = 2'b10} state_t;

   function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      case (op)
         3'b000:  alu_f = ~(a | b);
         3'b001:  alu_f = a + b;
         3'b010:  alu_f = a - b;
         3'b011:  alu_f = ~(a & b);
         3'b100:  alu_f = a & b;
         3'b101:  alu_f = a | b;
         3'b110:  alu_f = a ^ b;
         default: alu_f = {DATA_W{1'b0}};
      endcase
   endfunction

   logic [31:0]       imem_r [IMEM_WORDS];
   logic [DATA_W-1:0] rf_r [32];

   state_t            state_r, state_nxt_s;
   logic [AW-1:0]     pc_r;
   logic [31:0]       if_id_r;
   logic              id_ex_valid_r;
   logic [2:0]        id_ex_op_r;
   logic [4:0]        id_ex_rd_r;
   logic [DATA_W-1:0] id_ex_a_r, id_ex_b_r;
   logic              ex_wb_valid_r;
   logic [4:0]        ex_wb_rd_r;
   logic [DATA_W-1:0] ex_wb_data_r;
   logic [CNT_W-1:0]  retired_cnt_r, stall_cnt_r;

   logic              fetch_en_s, halted_s;
   logic [2:0]        id_op_s;
   logic [4:0]        id_rs_a_s, id_rs_b_s, id_rd_s;
   logic              id_valid_s, id_halt_s;
   logic [DATA_W-1:0] rf_a_s, rf_b_s, op_a_s, op_b_s, alu_s;
   logic              dep_a_s, dep_b_s, stall_s;

   // Halt/drain state register; frozen while run is low
   always_ff @(posedge clock) begin
      if (rst)
         state_r <= ST_RUN;
      else if (run)
         state_r <= state_nxt_s;
   end

   // Halt/drain next-state: HALT in ID starts the drain, empty ID_EX and EX_WB end it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (id_halt_s) state_nxt_s = ST_DRAIN;
            else           state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (!id_ex_valid_r && !ex_wb_valid_r) state_nxt_s = ST_HALT;
            else                                  state_nxt_s = ST_DRAIN;
         end
         ST_HALT: state_nxt_s = ST_HALT;
         default: state_nxt_s = ST_RUN;
      endcase
   end

   // Halt/drain outputs decoded from the state register
   always_comb begin
      fetch_en_s = (state_r == ST_RUN);
      halted_s   = (state_r == ST_HALT);
   end

   // Decode, write-through RF read, ALU and EX dependency resolution
   always_comb begin
      id_op_s    = if_id_r[17:15];
      id_rd_s    = if_id_r[14:10];
      id_rs_a_s  = if_id_r[9:5];
      id_rs_b_s  = if_id_r[4:0];
      id_valid_s = fetch_en_s && (if_id_r != NOP_WORD);
      id_halt_s  = id_valid_s && (id_op_s == 3'b111);
      if (ex_wb_valid_r && (ex_wb_rd_r == id_rs_a_s)) rf_a_s = ex_wb_data_r;
      else                                            rf_a_s = rf_r[id_rs_a_s];
      if (ex_wb_valid_r && (ex_wb_rd_r == id_rs_b_s)) rf_b_s = ex_wb_data_r;
      else                                            rf_b_s = rf_r[id_rs_b_s];
      alu_s   = alu_f(id_ex_op_r, id_ex_a_r, id_ex_b_r);
      // HALT is never placed in ID_EX, so a valid ID_EX always carries a real rd
      dep_a_s = id_valid_s && !id_halt_s && id_ex_valid_r && (id_ex_rd_r == id_rs_a_s);
      dep_b_s = id_valid_s && !id_halt_s && id_ex_valid_r && (id_ex_rd_r == id_rs_b_s);
      if (FORWARD != 0) begin
         op_a_s  = dep_a_s ? alu_s : rf_a_s;
         op_b_s  = dep_b_s ? alu_s : rf_b_s;
         stall_s = 1'b0;
      end else begin
         op_a_s  = rf_a_s;
         op_b_s  = rf_b_s;
         stall_s = dep_a_s || dep_b_s;
      end
   end

   // Pipeline registers, PC and performance counters
   always_ff @(posedge clock) begin
      if (rst) begin
         pc_r          <= {AW{1'b0}};
         if_id_r       <= NOP_WORD;
         id_ex_valid_r <= 1'b0;
         id_ex_op_r    <= 3'b000;
         id_ex_rd_r    <= 5'd0;
         id_ex_a_r     <= {DATA_W{1'b0}};
         id_ex_b_r     <= {DATA_W{1'b0}};
         ex_wb_valid_r <= 1'b0;
         ex_wb_rd_r    <= 5'd0;
         ex_wb_data_r  <= {DATA_W{1'b0}};
         retired_cnt_r <= {CNT_W{1'b0}};
         stall_cnt_r   <= {CNT_W{1'b0}};
      end else if (run) begin
         if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end else if (fetch_en_s && !id_halt_s) begin
            if_id_r <= imem_r[pc_r];
            pc_r    <= pc_r + AW'(1);
         end else begin
            if_id_r <= NOP_WORD;
         end
         id_ex_valid_r <= id_valid_s && !id_halt_s && !stall_s;
         id_ex_op_r    <= id_op_s;
         id_ex_rd_r    <= id_rd_s;
         id_ex_a_r     <= op_a_s;
         id_ex_b_r     <= op_b_s;
         ex_wb_valid_r <= id_ex_valid_r;
         if (id_ex_valid_r) begin
            ex_wb_rd_r    <= id_ex_rd_r;
            ex_wb_data_r  <= alu_s;
            retired_cnt_r <= retired_cnt_r + CNT_W'(1);
         end
      end
   end

   // Instruction memory load port, usable only while frozen
   always_ff @(posedge clock) begin
      if (!run && bus.imem_we)
         imem_r[bus.imem_waddr] <= bus.imem_wdata;
   end

   // Register file: preload while frozen, writeback from EX_WB while running (dropped on rst)
   always_ff @(posedge clock) begin
      if (!run) begin
         if (bus.rf_we)
            rf_r[bus.rf_waddr] <= bus.rf_wdata;
      end else if (!rst && ex_wb_valid_r) begin
         rf_r[ex_wb_rd_r] <= ex_wb_data_r;
      end
   end

   assign bus.wb_valid = ex_wb_valid_r;
   assign bus.wb_rd    = ex_wb_rd_r;
   assign bus.wb_data  = ex_wb_data_r;
   assign halted       = halted_s;
   assign retired_cnt  = retired_cnt_r;
   assign stall_cnt    = stall_cnt_r;
endmodule

// File: tb/tb_risc_pipe_core.sv
// Directed bench: three cores (forwarding, interlock, 4-word IMEM) share clock, reset and load bus.
module tb_risc_pipe_core;
   logic        clock = 1'b0;
   logic        rst, run_ab, run_c;
   logic        imem_we, rf_we;
   logic [3:0]  imem_waddr;
   logic [31:0] imem_wdata, rf_wdata;
   logic [4:0]  rf_waddr;
   logic        halted_a, halted_b, halted_c;
   logic [15:0] ret_a, ret_b, ret_c, stl_a, stl_b, stl_c;
   int          compared = 0;
   int          mismatched = 0;

   always #5 clock = ~clock;

   risc_pipe_core_if #(.DATA_W(32), .IMEM_WORDS(16)) if_a ();
   risc_pipe_core_if #(.DATA_W(32), .IMEM_WORDS(16)) if_b ();
   risc_pipe_core_if #(.DATA_W(32), .IMEM_WORDS(4))  if_c ();

   assign if_a.imem_we = imem_we;  assign if_a.imem_waddr = imem_waddr;
   assign if_a.imem_wdata = imem_wdata;
   assign if_a.rf_we = rf_we;  assign if_a.rf_waddr = rf_waddr;  assign if_a.rf_wdata = rf_wdata;
   assign if_b.imem_we = imem_we;  assign if_b.imem_waddr = imem_waddr;
   assign if_b.imem_wdata = imem_wdata;
   assign if_b.rf_we = rf_we;  assign if_b.rf_waddr = rf_waddr;  assign if_b.rf_wdata = rf_wdata;
   assign if_c.imem_we = imem_we;  assign if_c.imem_waddr = imem_waddr[1:0];
   assign if_c.imem_wdata = imem_wdata;
   assign if_c.rf_we = rf_we;  assign if_c.rf_waddr = rf_waddr;  assign if_c.rf_wdata = rf_wdata;

   risc_pipe_core #(.DATA_W(32), .IMEM_WORDS(16), .FORWARD(1), .CNT_W(16)) u_a (
      .clock(clock), .rst(rst), .run(run_ab), .bus(if_a.slave),
      .halted(halted_a), .retired_cnt(ret_a), .stall_cnt(stl_a));
   risc_pipe_core #(.DATA_W(32), .IMEM_WORDS(16), .FORWARD(0), .CNT_W(16)) u_b (
      .clock(clock), .rst(rst), .run(run_ab), .bus(if_b.slave),
      .halted(halted_b), .retired_cnt(ret_b), .stall_cnt(stl_b));
   risc_pipe_core #(.DATA_W(32), .IMEM_WORDS(4), .FORWARD(1), .CNT_W(16)) u_c (
      .clock(clock), .rst(rst), .run(run_c), .bus(if_c.slave),
      .halted(halted_c), .retired_cnt(ret_c), .stall_cnt(stl_c));

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_imem(input logic [3:0] addr, input logic [31:0] data);
      imem_we = 1'b1; imem_waddr = addr; imem_wdata = data;
      tick(1);
      imem_we = 1'b0;
   endtask

   task automatic load_rf(input logic [4:0] addr, input logic [31:0] data);
      rf_we = 1'b1; rf_waddr = addr; rf_wdata = data;
      tick(1);
      rf_we = 1'b0;
   endtask

   task automatic load_t1_prog();
      load_imem(4'd0, 32'h0000_8C22);
      load_imem(4'd1, 32'h0001_1861);
      load_imem(4'd2, 32'h0003_8000);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic chk_wb_a(input string tag, input logic [4:0] rd, input logic [31:0] data);
      chk({tag, "_a_valid"}, {63'd0, if_a.wb_valid}, 64'd1);
      chk({tag, "_a_rd"}, {59'd0, if_a.wb_rd}, {59'd0, rd});
      chk({tag, "_a_data"}, {32'd0, if_a.wb_data}, {32'd0, data});
   endtask

   task automatic chk_wb_b(input string tag, input logic [4:0] rd, input logic [31:0] data);
      chk({tag, "_b_valid"}, {63'd0, if_b.wb_valid}, 64'd1);
      chk({tag, "_b_rd"}, {59'd0, if_b.wb_rd}, {59'd0, rd});
      chk({tag, "_b_data"}, {32'd0, if_b.wb_data}, {32'd0, data});
   endtask

   initial begin
      rst = 1'b1; run_ab = 1'b0; run_c = 1'b0;
      imem_we = 1'b0; imem_waddr = 4'd0; imem_wdata = 32'd0;
      rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
      tick(2);
      chk("rst_wb_valid", {63'd0, if_a.wb_valid}, 64'd0);
      chk("rst_wb_rd", {59'd0, if_a.wb_rd}, 64'd0);
      chk("rst_wb_data", {32'd0, if_a.wb_data}, 64'd0);
      chk("rst_halted", {63'd0, halted_a}, 64'd0);
      chk("rst_retired", {48'd0, ret_a}, 64'd0);
      chk("rst_stall", {48'd0, stl_b}, 64'd0);
      rst = 1'b0;

      // Forwarding vs interlock on R3=R1+R2, R6=R3-R1, HALT
      load_t1_prog();
      load_rf(5'd1, 32'd40);
      load_rf(5'd2, 32'd60);
      run_ab = 1'b1;
      tick(3);
      chk_wb_a("t1_add", 5'd3, 32'd100);
      chk_wb_b("t2_add", 5'd3, 32'd100);
      tick(1);
      chk_wb_a("t1_sub", 5'd6, 32'd60);
      chk("t2_bubble", {63'd0, if_b.wb_valid}, 64'd0);
      tick(1);
      chk_wb_b("t2_sub", 5'd6, 32'd60);
      chk("t1_halt_early", {63'd0, halted_a}, 64'd0);
      tick(1);
      chk("t1_halted", {63'd0, halted_a}, 64'd1);
      chk("t2_halt_early", {63'd0, halted_b}, 64'd0);
      tick(1);
      chk("t2_halted", {63'd0, halted_b}, 64'd1);
      chk("t1_retired", {48'd0, ret_a}, 64'd2);
      chk("t1_stall", {48'd0, stl_a}, 64'd0);
      chk("t2_retired", {48'd0, ret_b}, 64'd2);
      chk("t2_stall", {48'd0, stl_b}, 64'd1);
      run_ab = 1'b0;

      // Logic ops, RF write ignored while running, freeze with RF write honoured
      pulse_rst();
      chk("t3_halt_cleared", {63'd0, halted_a}, 64'd0);
      load_imem(4'd0, 32'h0000_30EB);
      load_imem(4'd1, 32'h0001_B4EB);
      load_imem(4'd2, 32'h0003_38EB);
      load_imem(4'd3, 32'h0002_D694);
      load_imem(4'd4, 32'h0003_8000);
      load_rf(5'd7, 32'hFFFF_856D);
      load_rf(5'd11, 32'hFFFF_765E);
      run_ab = 1'b1;
      rf_we = 1'b1; rf_waddr = 5'd11; rf_wdata = 32'd0;
      tick(1);
      rf_we = 1'b0;
      tick(2);
      chk_wb_a("t3_nor", 5'd12, 32'h0000_0880);
      chk("t5_ret_before", {48'd0, ret_a}, 64'd1);
      run_ab = 1'b0;
      rf_we = 1'b1; rf_waddr = 5'd20; rf_wdata = 32'h1234_5678;
      tick(1);
      rf_we = 1'b0;
      tick(2);
      chk_wb_a("t5_hold", 5'd12, 32'h0000_0880);
      chk("t5_ret_hold", {48'd0, ret_a}, 64'd1);
      chk("t5_stall_hold", {48'd0, stl_a}, 64'd0);
      run_ab = 1'b1;
      tick(1);
      chk_wb_a("t3_nand", 5'd13, 32'h0000_FBB3);
      chk_wb_b("t3_nand", 5'd13, 32'h0000_FBB3);
      tick(1);
      chk_wb_a("t3_xor", 5'd14, 32'h0000_F333);
      tick(1);
      chk_wb_a("t5_rf_load", 5'd21, 32'h1234_5678);
      tick(2);
      chk("t3_halted", {63'd0, halted_a}, 64'd1);
      chk("t3_retired", {48'd0, ret_a}, 64'd4);
      chk("t3_retired_b", {48'd0, ret_b}, 64'd4);
      chk("t3_stall_b", {48'd0, stl_b}, 64'd0);
      run_ab = 1'b0;

      // Reset while the SUB is in EX
      pulse_rst();
      load_t1_prog();
      run_ab = 1'b1;
      tick(3);
      chk_wb_a("t6_pre", 5'd3, 32'd100);
      chk("t6_pre_ret", {48'd0, ret_a}, 64'd1);
      chk("t6_pre_stall_b", {48'd0, stl_b}, 64'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6_wb_valid", {63'd0, if_a.wb_valid}, 64'd0);
      chk("t6_ret", {48'd0, ret_a}, 64'd0);
      chk("t6_stall_b", {48'd0, stl_b}, 64'd0);
      chk("t6_halted", {63'd0, halted_a}, 64'd0);
      tick(3);
      chk_wb_a("t6_rerun", 5'd3, 32'd100);
      chk("t6_rerun_ret", {48'd0, ret_a}, 64'd1);
      run_ab = 1'b0;

      // PC wrap on the 4-word core with four independent ADDs
      pulse_rst();
      load_imem(4'd0, 32'h0000_C022);
      load_imem(4'd1, 32'h0000_C422);
      load_imem(4'd2, 32'h0000_C822);
      load_imem(4'd3, 32'h0000_CC22);
      run_c = 1'b1;
      tick(8);
      chk("t4_wrap_valid", {63'd0, if_c.wb_valid}, 64'd1);
      chk("t4_wrap_rd", {59'd0, if_c.wb_rd}, 64'd17);
      chk("t4_wrap_data", {32'd0, if_c.wb_data}, 64'd100);
      tick(2);
      chk("t4_last_rd", {59'd0, if_c.wb_rd}, 64'd19);
      chk("t4_retired", {48'd0, ret_c}, 64'd8);
      chk("t4_stall", {48'd0, stl_c}, 64'd0);
      chk("t4_halted", {63'd0, halted_c}, 64'd0);
      run_c = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
